// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default-geometry constants for the cache line <-> memory burst adaptor.
package cacheline_adaptor_pkg;

  localparam int DEF_LINE_WIDTH  = 256;
  localparam int DEF_BURST_WIDTH = 64;
  localparam int BEATS           = DEF_LINE_WIDTH / DEF_BURST_WIDTH;
  localparam int OFFSET_BITS     = $clog2(DEF_LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Transaction kind, remembered across a burst for the perf counters.
  typedef enum logic {
    READ_T  = 1'b0,
    WRITE_T = 1'b1
  } cycle_type_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache line adaptor: turns one line read/write-back into a burst of memory beats
// and answers the cache with a single-cycle resp_o.
// Optional perf counters (rd_count_o / wr_count_o) under CACHELINE_ADAPTOR_PERF_EN.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]            rd_count_o,
  output logic [31:0]            wr_count_o
`endif
);

  localparam int NB  = LINE_WIDTH / BURST_WIDTH;
  localparam int OFF = $clog2(LINE_WIDTH / 8);
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;

  state_e                  state_q, state_d;
  logic [CW-1:0]           k_q, k_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wline_q, wline_d;
  logic [LINE_WIDTH-1:0]   rline_q, rline_d;
  logic [ADDR_WIDTH-1:0]   addr_aligned;
  logic                    last_beat;

  // Byte-offset bits are dropped on purpose; the memory only sees line addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[OFF-1:0];

  assign addr_aligned = {address_i[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
  assign last_beat    = (k_q == CW'(NB - 1));

  // State and datapath registers; rst also clears the assembled line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Next state: accept in IDLE (write wins), count beats on resp_i, pulse once in DONE.
  // The counter stops on the last beat rather than wrapping; DONE clears it.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          addr_d  = addr_aligned;
          wline_d = line_i;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = addr_aligned;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          rline_d[int'(k_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          if (last_beat) state_d = DONE;
          else           k_d     = k_q + CW'(1);
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (last_beat) state_d = DONE;
          else           k_d     = k_q + CW'(1);
        end
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = rline_q;
  assign burst_o   = wline_q[int'(k_q)*BURST_WIDTH +: BURST_WIDTH];

`ifdef CACHELINE_ADAPTOR_PERF_EN
  cycle_type_e typ_q;

  // Remember which kind of transaction was accepted so DONE credits the right counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      typ_q <= READ_T;
    end else if (state_q == IDLE) begin
      if (write_i)     typ_q <= WRITE_T;
      else if (read_i) typ_q <= READ_T;
    end
  end

  // Saturating completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (state_q == DONE) begin
      if (typ_q == READ_T && rd_count_o != 32'hFFFF_FFFF)
        rd_count_o <= rd_count_o + 32'd1;
      if (typ_q == WRITE_T && wr_count_o != 32'hFFFF_FFFF)
        wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor (256-bit line, 64-bit beats).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0]  rd_count_o, wr_count_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    .rd_count_o(rd_count_o),
    .wr_count_o(wr_count_o)
`endif
  );

  // One rising edge, then back to the falling edge where the bench samples and drives.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    line_i = '0; address_i = '0; burst_i = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (resp_o !== 1'b0)     $display("FAIL reset_resp got %b exp 0", resp_o);     if (resp_o !== 1'b0) errors++;
    checks++; if (read_o !== 1'b0)     begin errors++; $display("FAIL reset_read got %b exp 0", read_o); end
    checks++; if (write_o !== 1'b0)    begin errors++; $display("FAIL reset_write got %b exp 0", write_o); end
    checks++; if (line_o !== 256'h0)   begin errors++; $display("FAIL reset_line got %h exp 0", line_o); end
    checks++; if (address_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", address_o); end
    checks++; if (burst_o !== 64'h0)   begin errors++; $display("FAIL reset_burst got %h exp 0", burst_o); end
    // resp_i while idle must not store a beat or start anything
    resp_i = 1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    resp_i = 0;
    checks++; if (line_o !== 256'h0) begin errors++; $display("FAIL idle_resp_line got %h exp 0", line_o); end
    checks++; if (read_o !== 1'b0 || write_o !== 1'b0) begin errors++; $display("FAIL idle_resp_req got rd=%b wr=%b exp 0 0", read_o, write_o); end
  endtask

  task automatic test_read_zero_wait();
    logic [63:0] b [4];
    b[0] = {16{4'h1}}; b[1] = {16{4'h2}}; b[2] = {16{4'h3}}; b[3] = {16{4'h4}};
    read_i = 1; address_i = 32'h0000_1234;
    tick(); // request seen in IDLE at t; now in cycle t+1
    checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL rd_read_o got %b exp 1", read_o); end
    checks++; if (address_o !== 32'h0000_1220) begin errors++; $display("FAIL rd_addr got %h exp 00001220", address_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL rd_early_resp beat %0d got %b exp 0", i, resp_o); end
      resp_i = 1; burst_i = b[i];
      tick();
    end
    // cycle t+5
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL rd_resp got %b exp 1", resp_o); end
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL rd_read_drop got %b exp 0", read_o); end
    checks++; if (line_o !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL rd_line got %h exp %h", line_o, {b[3], b[2], b[1], b[0]}); end
    exp_rd++;
    read_i = 0; resp_i = 0;
    tick();
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL rd_resp_one_cycle got %b exp 0", resp_o); end
    checks++; if (line_o !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL rd_line_hold got %h", line_o); end
  endtask

  task automatic test_write_waits();
    logic [63:0] d [4];
    logic [63:0] exp_b [6];
    logic        pat [6];
    d[0] = {8{8'hD0}}; d[1] = {8{8'hD1}}; d[2] = {8{8'hD2}}; d[3] = {8{8'hD3}};
    exp_b[0] = d[0]; exp_b[1] = d[1]; exp_b[2] = d[1]; exp_b[3] = d[1]; exp_b[4] = d[2]; exp_b[5] = d[3];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 1;
    write_i = 1; address_i = 32'h0000_0A5F; line_i = {d[3], d[2], d[1], d[0]};
    tick();
    line_i = '1; // latched copy must be used
    checks++; if (address_o !== 32'h0000_0A40) begin errors++; $display("FAIL wr_addr got %h exp 00000a40", address_o); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (write_o !== 1'b1) begin errors++; $display("FAIL wr_write_o cyc %0d got %b exp 1", i, write_o); end
      checks++; if (burst_o !== exp_b[i]) begin errors++; $display("FAIL wr_burst cyc %0d got %h exp %h", i, burst_o, exp_b[i]); end
      checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL wr_early_resp cyc %0d got %b exp 0", i, resp_o); end
      resp_i = pat[i];
      tick();
    end
    checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL wr_write_drop got %b exp 0", write_o); end
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL wr_resp got %b exp 1", resp_o); end
    exp_wr++;
    write_i = 0; resp_i = 0;
    tick();
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL wr_resp_one_cycle got %b exp 0", resp_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] b [4];
    int pulses;
    b[0] = 64'hA0A0_0000_0000_0001; b[1] = 64'hA1A1_0000_0000_0002;
    b[2] = 64'hA2A2_0000_0000_0003; b[3] = 64'hA3A3_0000_0000_0004;
    pulses = 0;
    write_i = 1; address_i = 32'h0000_3000; line_i = {4{64'hCAFE_F00D_0000_0000}};
    resp_i = 1; burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (resp_o) pulses++;
      tick();
    end
    if (resp_o) pulses++;
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL b2b_wr_resp got %b exp 1", resp_o); end
    exp_wr++;
    // fill request arrives while DONE; must not be accepted until IDLE
    write_i = 0; read_i = 1; address_i = 32'h0000_2008;
    tick();
    if (resp_o) pulses++;
    checks++; if (read_o !== 1'b0 || write_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got rd=%b wr=%b exp 0 0", read_o, write_o); end
    tick();
    checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL b2b_rd_accept got %b exp 1", read_o); end
    checks++; if (address_o !== 32'h0000_2000) begin errors++; $display("FAIL b2b_rd_addr got %h exp 00002000", address_o); end
    for (int i = 0; i < 4; i++) begin
      if (resp_o) pulses++;
      burst_i = b[i];
      tick();
    end
    if (resp_o) pulses++;
    checks++; if (line_o !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL b2b_line got %h exp %h", line_o, {b[3], b[2], b[1], b[0]}); end
    exp_rd++;
    read_i = 0; resp_i = 0;
    tick();
    if (resp_o) pulses++;
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
  endtask

  task automatic test_simultaneous();
    read_i = 1; write_i = 1; address_i = 32'h0000_5000; line_i = {4{64'h1357_9BDF_2468_ACE0}};
    tick();
    checks++; if (write_o !== 1'b1) begin errors++; $display("FAIL sim_write_o got %b exp 1", write_o); end
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL sim_read_o got %b exp 0", read_o); end
    read_i = 0; write_i = 0; resp_i = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL sim_resp got %b exp 1", resp_o); end
    exp_wr++;
    resp_i = 0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] b [4];
    b[0] = 64'h0123_4567_89AB_CDEF; b[1] = 64'hFEDC_BA98_7654_3210;
    b[2] = 64'h0F0F_0F0F_F0F0_F0F0; b[3] = 64'h5555_AAAA_5555_AAAA;
    read_i = 1; address_i = 32'h0000_1000;
    tick();
    resp_i = 1; burst_i = 64'h7777_7777_7777_7777;
    tick(); tick(); tick(); // three beats stored
    resp_i = 0; rst = 1;
    tick();
    rst = 0; read_i = 0;
    exp_rd = 0; exp_wr = 0;
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL rst_read_o got %b exp 0", read_o); end
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL rst_resp_o got %b exp 0", resp_o); end
    checks++; if (line_o !== 256'h0) begin errors++; $display("FAIL rst_line got %h exp 0", line_o); end
    // new read from 0x40, request dropped after acceptance, one wait cycle
    read_i = 1; address_i = 32'h0000_0040;
    tick();
    read_i = 0;
    checks++; if (address_o !== 32'h0000_0040) begin errors++; $display("FAIL rst_rd_addr got %h exp 00000040", address_o); end
    resp_i = 1; burst_i = b[0]; tick();
    resp_i = 0; burst_i = 64'hBAD1_BAD1_BAD1_BAD1; tick();
    checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL rst_rd_wait got %b exp 1", read_o); end
    for (int i = 1; i < 4; i++) begin
      resp_i = 1; burst_i = b[i];
      tick();
    end
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL rst_rd_resp got %b exp 1", resp_o); end
    checks++; if (line_o !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL rst_rd_line got %h exp %h", line_o, {b[3], b[2], b[1], b[0]}); end
    exp_rd++;
    resp_i = 0;
    tick();
  endtask

`ifdef CACHELINE_ADAPTOR_PERF_EN
  task automatic test_perf();
    for (int n = 0; n < 2; n++) begin
      read_i = 1; address_i = 32'h100 * n; tick();
      read_i = 0; resp_i = 1;
      for (int i = 0; i < 4; i++) tick();
      resp_i = 0; exp_rd++; tick();
    end
    checks++; if (rd_count_o !== 32'(exp_rd)) begin errors++; $display("FAIL perf_rd got %0d exp %0d", rd_count_o, exp_rd); end
    checks++; if (wr_count_o !== 32'(exp_wr)) begin errors++; $display("FAIL perf_wr got %0d exp %0d", wr_count_o, exp_wr); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_read();
`ifdef CACHELINE_ADAPTOR_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
